// File: rtl/fft_sched_pkg.sv
// Shared types and constants for the FFT frame scheduler.
package fft_sched_pkg;

    localparam int unsigned NPTS     = 16;
    localparam int unsigned SAMPLE_W = 24;
    localparam int unsigned BIN_W    = 16;

    typedef logic [NPTS*SAMPLE_W-1:0] frame_t;
    typedef logic [NPTS*BIN_W-1:0]    bins_t;

    typedef enum logic [1:0] {IDLE, ARM, RUN, HOLD} state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Signal bundle between mic front end / FFT processor / VGA and the scheduler.
interface fft_frame_scheduler_if;
    import fft_sched_pkg::*;

    logic       new_t;
    frame_t     t_in;
    logic       fft_start;
    frame_t     fft_t;
    logic       fft_done;
    bins_t      fft_f;
    logic       vsync;
    bins_t      disp_f;
    logic       disp_valid;
    logic       busy;
    logic [7:0] drop_cnt;
    logic [7:0] timeout_cnt;

    modport slave (
        input  new_t, t_in, fft_done, fft_f, vsync,
        output fft_start, fft_t, disp_f, disp_valid, busy, drop_cnt, timeout_cnt
    );

    modport master (
        output new_t, t_in, fft_done, fft_f, vsync,
        input  fft_start, fft_t, disp_f, disp_valid, busy, drop_cnt, timeout_cnt
    );

endinterface

// File: rtl/fft_sched_watchdog.sv
// Completion watchdog: load to TIMEOUT-1, count down while running, flag zero.
module fft_sched_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic run_i,
    output logic expired_o
);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= CNT_W'(TIMEOUT - 1);
        end else if (run_i && cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/fft_frame_scheduler.sv
// FFT frame scheduler: capture, start, watchdog, one-deep shadow, vsync-aligned commit.
// Optional frame decimation is enabled with `define FFT_DECIM_EN.
module fft_frame_scheduler
    import fft_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1024
`ifdef FFT_DECIM_EN
    , parameter int unsigned DECIM = 4
`endif
) (
    input logic                  clk,
    input logic                  reset,
    fft_frame_scheduler_if.slave bus
);
    state_t     state_q;
    frame_t     fft_t_q, shadow_q;
    bins_t      pending_q, disp_f_q;
    logic       shadow_v_q, disp_valid_q, fft_start_q, vsync_q;
    logic [7:0] drop_q, tmo_q;
    logic       wd_expired, take_new, vsync_fall, consume;

`ifdef FFT_DECIM_EN
    localparam int unsigned DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    logic [DW-1:0] decim_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            decim_q <= '0;
        end else if (bus.new_t) begin
            decim_q <= (32'(decim_q) == DECIM - 1) ? '0 : decim_q + DW'(1);
        end
    end

    assign take_new = bus.new_t && (decim_q == '0);
`else
    assign take_new = bus.new_t;
`endif

    assign vsync_fall = vsync_q && !bus.vsync;
    // Shadow leaves the buffer this cycle; a coincident new_t refills it without a drop.
    assign consume = shadow_v_q &&
                     ((state_q == IDLE && !take_new) || (state_q == HOLD && vsync_fall));

    fft_sched_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .clk      (clk),
        .reset    (reset),
        .load_i   (state_q == ARM),
        .run_i    (state_q == RUN),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fft_t_q      <= '0;
            shadow_q     <= '0;
            shadow_v_q   <= 1'b0;
            pending_q    <= '0;
            disp_f_q     <= '0;
            disp_valid_q <= 1'b0;
            fft_start_q  <= 1'b0;
            vsync_q      <= 1'b1;
            drop_q       <= '0;
            tmo_q        <= '0;
        end else begin
            fft_start_q <= 1'b0;
            vsync_q     <= bus.vsync;
            case (state_q)
                IDLE: begin
                    if (take_new) begin
                        fft_t_q     <= bus.t_in;
                        fft_start_q <= 1'b1;
                        state_q     <= ARM;
                    end else if (shadow_v_q) begin
                        fft_t_q     <= shadow_q;
                        fft_start_q <= 1'b1;
                        state_q     <= ARM;
                    end
                end
                ARM: state_q <= RUN;
                RUN: begin
                    if (bus.fft_done) begin
                        pending_q <= bus.fft_f;
                        state_q   <= HOLD;
                    end else if (wd_expired) begin
                        tmo_q   <= sat_inc(tmo_q);
                        state_q <= IDLE;
                    end
                end
                HOLD: begin
                    if (vsync_fall) begin
                        disp_f_q     <= pending_q;
                        disp_valid_q <= 1'b1;
                        if (shadow_v_q) begin
                            fft_t_q     <= shadow_q;
                            fft_start_q <= 1'b1;
                            state_q     <= ARM;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (take_new && state_q != IDLE) begin
                shadow_q   <= bus.t_in;
                shadow_v_q <= 1'b1;
                if (shadow_v_q && !consume) drop_q <= sat_inc(drop_q);
            end else if (consume) begin
                shadow_v_q <= 1'b0;
            end
        end
    end

    assign bus.fft_start   = fft_start_q;
    assign bus.fft_t       = fft_t_q;
    assign bus.disp_f      = disp_f_q;
    assign bus.disp_valid  = disp_valid_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.drop_cnt    = drop_q;
    assign bus.timeout_cnt = tmo_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler (TIMEOUT=8; DECIM=4 when FFT_DECIM_EN is defined).
module tb_fft_frame_scheduler;
    import fft_sched_pkg::*;

    localparam int TIMEOUT = 8;
`ifdef FFT_DECIM_EN
    localparam int DECIM = 4;
`endif

    logic clk;
    logic reset;
    fft_frame_scheduler_if bus();

`ifdef FFT_DECIM_EN
    fft_frame_scheduler #(.TIMEOUT(TIMEOUT), .DECIM(DECIM)) dut (.clk(clk), .reset(reset), .bus(bus));
`else
    fft_frame_scheduler #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .reset(reset), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input bit ok,
                         input logic [NPTS*SAMPLE_W-1:0] act, input logic [NPTS*SAMPLE_W-1:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Transaction-level reference: one frame in flight, one pending slot, newest wins.
    frame_t     start_q[$];
    bins_t      disp_q[$];
    bit         m_busy, m_sh_v;
    frame_t     m_sh;
    int         m_drop, m_tmo, exp_starts;
    int unsigned m_dec;
    bit         armed_seen;

    function automatic void m_new(input frame_t f);
`ifdef FFT_DECIM_EN
        bit take;
        take = (m_dec % DECIM) == 0;
        m_dec++;
        if (!take) return;
`endif
        if (!m_busy) begin
            start_q.push_back(f);
            m_busy = 1'b1;
            exp_starts++;
        end else begin
            if (m_sh_v && m_drop < 255) m_drop++;
            m_sh   = f;
            m_sh_v = 1'b1;
        end
    endfunction

    function automatic void m_end(input bit timed_out);
        if (timed_out && m_tmo < 255) m_tmo++;
        if (m_sh_v) begin
            start_q.push_back(m_sh);
            m_sh_v = 1'b0;
            exp_starts++;
        end else begin
            m_busy = 1'b0;
        end
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < int'(NPTS*SAMPLE_W/32); i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    function automatic bins_t rand_bins();
        bins_t b;
        for (int i = 0; i < int'(NPTS*BIN_W/32); i++) b[i*32 +: 32] = $urandom;
        return b;
    endfunction

    // Monitor: pops expectations whenever the DUT starts a frame or updates the display.
    int    dut_starts = 0;
    bins_t disp_prev  = '0;
    bit    vs1 = 1'b1, vs2 = 1'b1;

    always @(negedge clk) begin
        frame_t ef;
        bins_t  eb;
        if (!reset) begin
            disp_prev = bus.disp_f;
            vs1 = 1'b1;
            vs2 = 1'b1;
        end else begin
            if (bus.fft_start) begin
                dut_starts++;
                check("start_expected", start_q.size() != 0, start_q.size(), 1);
                if (start_q.size() != 0) begin
                    ef = start_q.pop_front();
                    check("start_frame", bus.fft_t == ef, bus.fft_t, ef);
                end
            end
            if (bus.disp_f !== disp_prev) begin
                check("commit_expected", disp_q.size() != 0, disp_q.size(), 1);
                if (disp_q.size() != 0) begin
                    eb = disp_q.pop_front();
                    check("commit_bins", bus.disp_f == eb, bus.disp_f, eb);
                end
                check("commit_on_vsync_fall", vs2 && !vs1, {vs2, vs1}, 2'b10);
                disp_prev = bus.disp_f;
            end
            vs2 = vs1;
            vs1 = bus.vsync;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_new(input frame_t f);
        bus.new_t = 1'b1;
        bus.t_in  = f;
        m_new(f);
    endtask

    task automatic new_frame(input frame_t f);
        tick();
        drive_new(f);
        tick();
        bus.new_t = 1'b0;
    endtask

    task automatic wait_start(output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        if (armed_seen) begin
            armed_seen = 1'b0;
            ok = 1'b1;
            return;
        end
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (bus.fft_start) begin
                ok = 1'b1;
                n  = i;
                break;
            end
        end
        check("start_within_bound", ok, ok, 1);
    endtask

    // k=0: processor never answers; otherwise fft_done in the k-th RUN cycle.
    task automatic do_job(input int k, input int n_extra, input int vs_after,
                          input bit newt_commit, output int lat);
        bit    ok, exp_st;
        bins_t b;
        int    cyc;
        wait_start(ok, lat);
        if (!ok) return;
        tick();
        cyc = 1;
        for (int i = 0; i < n_extra; i++) begin
            drive_new(rand_frame());
            tick();
            bus.new_t = 1'b0;
            cyc++;
        end
        if (k == 0) begin
            while (cyc < TIMEOUT + 1) begin
                tick();
                cyc++;
            end
            @(negedge clk);
            check("idle_after_timeout", bus.busy == 1'b0, bus.busy, 0);
            m_end(1'b1);
        end else begin
            while (cyc < k) begin
                tick();
                cyc++;
            end
            b = rand_bins();
            bus.fft_done = 1'b1;
            bus.fft_f    = b;
            disp_q.push_back(b);
            tick();
            bus.fft_done = 1'b0;
            repeat (vs_after) tick();
            bus.vsync = 1'b0;
            m_end(1'b0);
            exp_st = m_busy;
            if (newt_commit) drive_new(rand_frame());
            tick();
            bus.vsync = 1'b1;
            bus.new_t = 1'b0;
            @(negedge clk);
            check("disp_valid_after_commit", bus.disp_valid == 1'b1, bus.disp_valid, 1);
            check("start_after_commit", bus.fft_start == exp_st, bus.fft_start, exp_st);
            if (exp_st && bus.fft_start) armed_seen = 1'b1;
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_drop_cnt"}, bus.drop_cnt == 8'(m_drop), bus.drop_cnt, m_drop);
        check({tag, "_timeout_cnt"}, bus.timeout_cnt == 8'(m_tmo), bus.timeout_cnt, m_tmo);
    endtask

    task automatic start_one();
        while (!m_busy) new_frame(rand_frame());
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        frame_t a;
        int     lat, k, n_extra, starts0, exp0, spaced_exp;
        bit     ok;

        reset = 1'b0;
        bus.new_t = 1'b0;
        bus.t_in = '0;
        bus.fft_done = 1'b0;
        bus.fft_f = '0;
        bus.vsync = 1'b1;
        m_busy = 0; m_sh_v = 0; m_sh = '0; m_drop = 0; m_tmo = 0; m_dec = 0;
        exp_starts = 0; armed_seen = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", bus.busy == 1'b0, bus.busy, 0);
        check("rst_fft_start", bus.fft_start == 1'b0, bus.fft_start, 0);
        check("rst_fft_t", bus.fft_t == '0, bus.fft_t, 0);
        check("rst_disp_f", bus.disp_f == '0, bus.disp_f, 0);
        check("rst_disp_valid", bus.disp_valid == 1'b0, bus.disp_valid, 0);
        check_counters("rst");
        tick();
        reset = 1'b1;

        // Single frame: start latency, hold-to-vsync commit, fft_t held afterwards.
        a = rand_frame();
        new_frame(a);
        do_job(5, 0, 9, 1'b0, lat);
        check("start_latency", lat == 1, lat, 1);
        check("fft_t_held", bus.fft_t == a, bus.fft_t, a);
        check_counters("single");

        // Watchdog expiry, then done on the expiry cycle.
        start_one();
        do_job(0, 0, 0, 1'b0, lat);
        check_counters("timeout");
        start_one();
        do_job(TIMEOUT, 0, 2, 1'b0, lat);
        check_counters("done_at_expiry");

        // Three frames during RUN of X: newest survives and starts right after commit.
        start_one();
        do_job(6, 3, 4, 1'b0, lat);
        check_counters("three_during_run");
        if (m_busy) do_job(2, 0, 1, 1'b0, lat);

        for (int it = 0; it < 40; it++) begin
            start_one();
            k = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            n_extra = (k == 0) ? int'($urandom_range(0, 3))
                               : int'($urandom_range(0, (k - 1 < 3) ? k - 1 : 3));
            do_job(k, n_extra, int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), lat);
            check_counters("random");
        end
        while (m_busy) do_job(0, 0, 0, 1'b0, lat);

        for (int i = 0; i < 300; i++) begin
            start_one();
            do_job(0, 0, 0, 1'b0, lat);
        end
        check("timeout_saturated", bus.timeout_cnt == 8'hFF, bus.timeout_cnt, 8'hFF);
        check_counters("saturation");

        // Eight widely spaced frames.
`ifdef FFT_DECIM_EN
        while (m_dec % DECIM != 0) new_frame(rand_frame());
        spaced_exp = (8 + DECIM - 1) / DECIM;
`else
        spaced_exp = 8;
`endif
        starts0 = dut_starts;
        exp0 = exp_starts;
        for (int i = 0; i < 8; i++) begin
            new_frame(rand_frame());
            if (m_busy) do_job(0, 0, 0, 1'b0, lat);
            repeat (12) @(posedge clk);
        end
        check("spaced_starts", dut_starts - starts0 == spaced_exp, dut_starts - starts0, spaced_exp);
        check("spaced_model", exp_starts - exp0 == spaced_exp, exp_starts - exp0, spaced_exp);
        check_counters("spaced");

        // Reset in the middle of RUN, followed by a stray fft_done.
        start_one();
        wait_start(ok, lat);
        repeat (3) tick();
        drive_new(rand_frame());
        tick();
        bus.new_t = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_busy", bus.busy == 1'b0, bus.busy, 0);
        check("midrst_fft_t", bus.fft_t == '0, bus.fft_t, 0);
        check("midrst_disp_valid", bus.disp_valid == 1'b0, bus.disp_valid, 0);
        check("midrst_timeout_cnt", bus.timeout_cnt == 8'h00, bus.timeout_cnt, 0);
        start_q.delete();
        disp_q.delete();
        m_busy = 0; m_sh_v = 0; m_drop = 0; m_tmo = 0; m_dec = 0; armed_seen = 0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        bus.fft_done = 1'b1;
        bus.fft_f = rand_bins();
        tick();
        bus.fft_done = 1'b0;
        repeat (2) tick();
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("postrst_busy", bus.busy == 1'b0, bus.busy, 0);
        check("postrst_disp_f", bus.disp_f == '0, bus.disp_f, 0);
        check("postrst_disp_valid", bus.disp_valid == 1'b0, bus.disp_valid, 0);
        check_counters("postrst");

        start_one();
        do_job(3, 1, 2, 1'b1, lat);
        while (m_busy) do_job(0, 0, 0, 1'b0, lat);
        repeat (5) tick();
        @(negedge clk);
        check_counters("final");
        check("starts_drained", start_q.size() == 0, start_q.size(), 0);
        check("commits_drained", disp_q.size() == 0, disp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
